// File: rtl/atd_serial_tx.sv
// ATD link transmitter: loads a parallel block and shifts it out MSB-first with a generated ATD_clk.
// Define ATD_TX_PARITY_EN to append an even-parity bit after bit 0.
//
// state | meaning
// IDLE  | ready for a block, ATD_clk/ATD_data low
// LOW   | ATD_clk low, current bit driven on ATD_data
// HIGH  | ATD_clk high, ATD_data stable for the receiver
// DONE  | one-cycle end-of-frame pulse on tx_done
module atd_serial_tx #(
    parameter int DATA_WIDTH = 128,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  ATD_data,
    output logic                  ATD_clk
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [7:0]        DIV_TC   = 8'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
`ifdef ATD_TX_PARITY_EN
    localparam logic              PAR_EN   = 1'b1;
`else
    localparam logic              PAR_EN   = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                state, state_nxt;
    logic [7:0]            div_cnt, div_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
    logic                  par_q, par_q_nxt;
    logic                  par_pend, par_pend_nxt;
    logic                  atd_clk_nxt, atd_data_nxt, tx_ready_nxt, tx_done_nxt;
    logic                  div_tc;

    assign div_tc = (div_cnt == DIV_TC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_q     <= 1'b0;
            par_pend  <= 1'b0;
            ATD_clk   <= 1'b0;
            ATD_data  <= 1'b0;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
            par_q     <= par_q_nxt;
            par_pend  <= par_pend_nxt;
            ATD_clk   <= atd_clk_nxt;
            ATD_data  <= atd_data_nxt;
            tx_ready  <= tx_ready_nxt;
            tx_done   <= tx_done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        div_nxt      = div_cnt;
        bit_nxt      = bit_cnt;
        shift_nxt    = shift_reg;
        par_q_nxt    = par_q;
        par_pend_nxt = par_pend;
        case (state)
            IDLE: begin
                if (tx_load) begin
                    state_nxt    = LOW;
                    shift_nxt    = tx_data;
                    bit_nxt      = LAST_BIT;
                    div_nxt      = '0;
                    par_q_nxt    = ^tx_data;
                    par_pend_nxt = PAR_EN;
                end
            end
            LOW: begin
                if (div_tc) begin
                    div_nxt   = '0;
                    state_nxt = HIGH;
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            HIGH: begin
                if (div_tc) begin
                    div_nxt = '0;
                    if (bit_cnt == '0) begin
                        // the parity bit reuses bit slot 0 once more
                        if (par_pend) begin
                            par_pend_nxt = 1'b0;
                            state_nxt    = LOW;
                        end else begin
                            state_nxt = DONE;
                        end
                    end else begin
                        shift_nxt = {shift_reg[DATA_WIDTH-2:0], 1'b0};
                        bit_nxt   = bit_cnt - 1'b1;
                        state_nxt = LOW;
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs are computed from the upcoming state so they land in registers
    always_comb begin
        atd_clk_nxt  = (state_nxt == HIGH);
        tx_ready_nxt = (state_nxt == IDLE);
        tx_done_nxt  = (state_nxt == DONE);
        atd_data_nxt = ATD_data;
        case (state_nxt)
            IDLE, DONE: atd_data_nxt = 1'b0;
            LOW: begin
                if (state != LOW) begin
                    if (state == HIGH && bit_cnt == '0)
                        atd_data_nxt = par_q;
                    else
                        atd_data_nxt = shift_nxt[DATA_WIDTH-1];
                end
            end
            default: atd_data_nxt = ATD_data;
        endcase
    end

endmodule

// File: tb/tb_atd_serial_tx.sv
// Directed bench for atd_serial_tx: receiver model samples ATD_data on ATD_clk rises.
module tb_atd_serial_tx;

    localparam int W   = 128;
    localparam int DIV = 4;
`ifdef ATD_TX_PARITY_EN
    localparam int NBITS = W + 1;
`else
    localparam int NBITS = W;
`endif
    localparam int FRAME_CYC = NBITS * 2 * DIV;
    localparam int FRAME_T   = FRAME_CYC * 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] tx_data = '0;
    logic         tx_load = 1'b0;
    logic         tx_ready, tx_done, ATD_data, ATD_clk;

    int n_cmp = 0;
    int n_bad = 0;

    int             rise_cnt = 0;
    int             hold_viol = 0;
    int             done_cnt = 0;
    logic [NBITS-1:0] rx = '0;
    logic           first_bit = 1'b0;
    logic           last_bit = 1'b0;
    logic           prev_clk = 1'b0;
    logic           prev_data = 1'b0;
    time            first_rise_t = 0;
    time            load_t = 0;
    time            done_t = 0;
    time            done_t1 = 0;
    logic           found;

    atd_serial_tx #(.DATA_WIDTH(W), .CLK_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .ATD_data (ATD_data),
        .ATD_clk  (ATD_clk)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ATD_clk === 1'b1 && prev_clk === 1'b0) begin
            rise_cnt++;
            rx       = {rx[NBITS-2:0], ATD_data};
            last_bit = ATD_data;
            if (rise_cnt == 1) begin
                first_rise_t = $time - 5;
                first_bit    = ATD_data;
            end
        end
        if (ATD_clk === 1'b1 && prev_clk === 1'b1 && ATD_data !== prev_data)
            hold_viol++;
        if (tx_done === 1'b1)
            done_cnt++;
        prev_clk  = ATD_clk;
        prev_data = ATD_data;
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_ctr();
        rise_cnt  = 0;
        hold_viol = 0;
        done_cnt  = 0;
        rx        = '0;
    endtask

    task automatic load(input logic [W-1:0] d, input logic hold);
        step();
        clear_ctr();
        tx_data = d;
        tx_load = 1'b1;
        @(posedge clk);
        load_t = $time;
        #1;
        tx_load = hold;
    endtask

    task automatic wait_done(input string tag);
        found = 1'b0;
        for (int i = 0; i < FRAME_CYC + 100 && !found; i++) begin
            step();
            if (tx_done === 1'b1) begin
                found  = 1'b1;
                done_t = $time - 6;
            end
        end
        check(tag, {127'd0, found}, 1);
    endtask

    function automatic logic [W-1:0] rx_word();
        return rx[NBITS-1 -: W];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d1, d2, da, db, ones;
        d1   = {1'b1, 126'd0, 1'b1};
        d2   = 128'h0123456789ABCDEF_FEDCBA9876543210;
        da   = {8{16'h5A5A}};
        db   = {8{16'hC3C3}};
        ones = '1;

        // reset and idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("idle_outputs", {124'd0, ATD_clk, ATD_data, tx_ready, tx_done}, 4'b0010);
        end

        // single-ended pattern, timing checks
        load(d1, 1'b0);
        wait_done("d1_done_seen");
        check("d1_first_rise", first_rise_t - load_t, DIV * 10);
        check("d1_first_bit", {127'd0, first_bit}, 1);
        check("d1_data", rx_word(), d1);
        check("d1_rises", rise_cnt, NBITS);
        check("d1_done_time", done_t - load_t, FRAME_T);
        check("d1_ready_in_done", {127'd0, tx_ready}, 0);
        step();
        check("d1_ready_after", {126'd0, tx_ready, tx_done}, 2'b10);
        check("d1_hold", hold_viol, 0);

        // mixed pattern through receiver model
        load(d2, 1'b0);
        wait_done("d2_done_seen");
        check("d2_data", rx_word(), d2);
        check("d2_rises", rise_cnt, NBITS);
        check("d2_hold", hold_viol, 0);

        // tx_load held high, tx_data changed mid-frame
        load(da, 1'b1);
        repeat (500) step();
        tx_data = db;
        wait_done("bb_done_seen");
        done_t1 = done_t;
        check("bb_first_data", rx_word(), da);
        check("bb_first_rises", rise_cnt, NBITS);
        step();
        check("bb_idle_ready", {127'd0, tx_ready}, 1);
        clear_ctr();
        step();
        check("bb_low_entry", {125'd0, tx_ready, ATD_clk, ATD_data}, 3'b001);
        tx_load = 1'b0;
        wait_done("bb2_done_seen");
        check("bb_second_rise", first_rise_t - done_t1, (2 + DIV) * 10);
        check("bb_second_data", rx_word(), db);

        // reset at bit 60
        load(ones, 1'b0);
        found = 1'b0;
        for (int i = 0; i < FRAME_CYC && !found; i++) begin
            step();
            if (rise_cnt >= W - 60) found = 1'b1;
        end
        check("rst_bit60_reached", {127'd0, found}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_outputs", {124'd0, ATD_clk, ATD_data, tx_ready, tx_done}, 4'b0010);
        clear_ctr();
        repeat (20) step();
        check("rst_no_done", done_cnt, 0);
        check("rst_no_rise", rise_cnt, 0);
        load(ones, 1'b0);
        wait_done("ones_done_seen");
        check("ones_data", rx_word(), ones);
        check("ones_rises", rise_cnt, NBITS);
        check("ones_done_time", done_t - load_t, FRAME_T);

`ifdef ATD_TX_PARITY_EN
        load(128'h7, 1'b0);
        wait_done("par_done_seen");
        check("par_rises", rise_cnt, W + 1);
        check("par_last_bit", {127'd0, last_bit}, 1);
        check("par_data", rx_word(), 128'h7);
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
